fp_mult_sched: RTL and testbench

Round-robin scheduler that shares one byte-serial FP64 multiplier (`fp_mult`) among N requesters. It accepts a 64-bit operand pair from the winning requester and streams 16 operand bytes into the multiplier, MSB first, A then B. It then collects the 8 result bytes and returns the assembled 64-bit product with the requester ID. Between operations it holds the multiplier in reset, because the multiplier performs exactly one operation per reset.

---
 rtl/fp_mult_sched.sv | 165 ++++++++++++++++
 tb/tb_fp_mult_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_sched.sv
// rtl/fp_mult_sched.sv - round-robin scheduler sharing one byte-serial FP64 multiplier among N requesters
module fp_mult_sched #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [N-1:0]      REQ_VALID,
    output logic [N-1:0]      REQ_READY,
    input  logic [N*64-1:0]   REQ_A,
    input  logic [N*64-1:0]   REQ_B,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [IDW-1:0]    RSP_ID,
    output logic [63:0]       RSP_DATA,
    output logic              RSP_TIMEOUT,
    output logic              MUL_RESET,
    output logic              MUL_ENABLE,
    output logic [7:0]        MUL_DATA_IN,
    input  logic [7:0]        MUL_DATA_OUT,
    input  logic              MUL_READY,
    output logic              BUSY
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [63:0] TIMEOUT_NAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, COLLECT, RESP} state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [127:0]     sreg;
    logic [3:0]       byte_cnt;
    logic [WCW-1:0]   wait_cnt;
    logic [2:0]       out_cnt;

    logic             found;
    logic [IDW-1:0]   gnt;
    logic [N-1:0]     gnt_oh;
    logic [63:0]      a_sel;
    logic [63:0]      b_sel;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    int               gi;

    // Rotate the request vector so bit 0 is the requester just after rr_ptr.
    always_comb begin
        found  = 1'b0;
        gnt    = '0;
        gnt_oh = '0;
        a_sel  = '0;
        b_sel  = '0;
        gi     = 0;
        dbl    = {REQ_VALID, REQ_VALID} >> (int'(rr_ptr) + 1);
        rot    = dbl[N-1:0];
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                gi    = int'(rr_ptr) + 1 + k;
                if (gi >= N) gi = gi - N;
                gnt   = IDW'(gi);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (found && gnt == IDW'(i)) begin
                gnt_oh[i] = 1'b1;
                a_sel     = REQ_A[i*64 +: 64];
                b_sel     = REQ_B[i*64 +: 64];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            rr_ptr      <= IDW'(N - 1);
            sreg        <= '0;
            byte_cnt    <= '0;
            wait_cnt    <= '0;
            out_cnt     <= '0;
            REQ_READY   <= '0;
            RSP_VALID   <= 1'b0;
            RSP_ID      <= '0;
            RSP_DATA    <= '0;
            RSP_TIMEOUT <= 1'b0;
            MUL_RESET   <= 1'b1;
            MUL_ENABLE  <= 1'b0;
            MUL_DATA_IN <= '0;
            BUSY        <= 1'b0;
        end else begin
            REQ_READY <= '0;
            case (state)
                IDLE: begin
                    MUL_RESET <= 1'b1;
                    if (found) begin
                        REQ_READY   <= gnt_oh;
                        sreg        <= {a_sel, b_sel};
                        rr_ptr      <= gnt;
                        RSP_ID      <= gnt;
                        MUL_RESET   <= 1'b0;
                        MUL_ENABLE  <= 1'b1;
                        MUL_DATA_IN <= a_sel[63:56];
                        byte_cnt    <= '0;
                        BUSY        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == 4'd15) begin
                        MUL_ENABLE  <= 1'b0;
                        MUL_DATA_IN <= '0;
                        wait_cnt    <= '0;
                        state       <= WAIT;
                    end else begin
                        MUL_DATA_IN <= sreg[119:112];
                        sreg        <= {sreg[119:0], 8'h00};
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (MUL_READY) begin
                        RSP_DATA[63:56] <= MUL_DATA_OUT;
                        out_cnt         <= 3'd1;
                        state           <= COLLECT;
                    end else if (wait_cnt >= WCW'(TIMEOUT - 1)) begin
                        RSP_DATA    <= TIMEOUT_NAN;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_VALID   <= 1'b1;
                        state       <= RESP;
                    end
                end
                COLLECT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (MUL_READY) begin
                        RSP_DATA[{3'd7 - out_cnt, 3'b000} +: 8] <= MUL_DATA_OUT;
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt == 3'd7) begin
                            RSP_VALID   <= 1'b1;
                            RSP_TIMEOUT <= 1'b0;
                            state       <= RESP;
                        end
                    end else if (wait_cnt >= WCW'(TIMEOUT - 1)) begin
                        RSP_DATA    <= TIMEOUT_NAN;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_VALID   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    // Multiplier stays out of reset until the response is taken.
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        MUL_RESET <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_sched.sv
// tb/tb_fp_mult_sched.sv - directed bench for fp_mult_sched with a byte-serial multiplier model
module tb_fp_mult_sched;

    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;
    localparam int LAT     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*64-1:0]   req_a = '0;
    logic [N*64-1:0]   req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [63:0]       rsp_data;
    logic              rsp_timeout;
    logic              mul_reset;
    logic              mul_enable;
    logic [7:0]        mul_data_in;
    logic [7:0]        mul_data_out = '0;
    logic              mul_ready = 1'b0;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    fp_mult_sched #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_A(req_a), .REQ_B(req_b),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
        .RSP_DATA(rsp_data), .RSP_TIMEOUT(rsp_timeout),
        .MUL_RESET(mul_reset), .MUL_ENABLE(mul_enable), .MUL_DATA_IN(mul_data_in),
        .MUL_DATA_OUT(mul_data_out), .MUL_READY(mul_ready), .BUSY(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: one operation per reset, LAT idle cycles, then 8 result bytes MSB first.
    logic [127:0] m_in = '0;
    logic [63:0]  m_res = '0;
    int m_state = 0, m_nin = 0, m_lat = 0, m_nout = 0, m_gapcnt = 0;
    int en_cnt = 0, en_first = -1, en_last = -1;
    bit m_stuck = 1'b0, m_gap = 1'b0;

    function automatic logic [63:0] mul_model(input logic [63:0] a, input logic [63:0] b);
        if (a == 64'h3FF8_0000_0000_0000 && b == 64'h4000_0000_0000_0000) return 64'h4008_0000_0000_0000;
        if (a == 64'h0 && b == 64'h7FF0_0000_0000_0000) return 64'h7FF0_0000_0000_0001;
        return a ^ b;
    endfunction

    always @(posedge clk) begin
        if (mul_reset) begin
            m_state <= 0; m_nin <= 0; m_lat <= 0; m_nout <= 0; m_gapcnt <= 0;
            mul_ready <= 1'b0; mul_data_out <= '0;
            en_cnt <= 0; en_first <= -1; en_last <= -1;
        end else begin
            if (mul_enable) begin
                en_cnt <= en_cnt + 1;
                if (en_first < 0) en_first <= cyc;
                en_last <= cyc;
            end
            case (m_state)
                0: if (mul_enable) begin
                    m_in  <= {m_in[119:0], mul_data_in};
                    m_nin <= m_nin + 1;
                    if (m_nin == 15) m_state <= 1;
                end
                1: begin
                    m_res <= mul_model(m_in[127:64], m_in[63:0]);
                    if (!m_stuck) begin
                        m_lat <= m_lat + 1;
                        if (m_lat == LAT - 1) m_state <= 2;
                    end
                end
                2: if (m_nout == 8) begin
                    mul_ready <= 1'b0;
                    m_state   <= 3;
                end else if (m_gap && m_nout == 3 && m_gapcnt < 2) begin
                    mul_ready <= 1'b0;
                    m_gapcnt  <= m_gapcnt + 1;
                end else begin
                    mul_ready    <= 1'b1;
                    mul_data_out <= m_res[63-8*m_nout -: 8];
                    m_nout       <= m_nout + 1;
                end
                default: mul_ready <= 1'b0;
            endcase
        end
    end

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
    endtask

    task automatic wait_grant(output int g, output bit ok);
        ok = 1'b0;
        g  = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                for (int j = 0; j < N; j++) if (req_ready[j]) g = j;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (mul_reset !== 1'b1) begin miscompares++; $display("FAIL reset_mul_reset: got %b want 1", mul_reset); end
        vectors++; if (mul_enable !== 1'b0) begin miscompares++; $display("FAIL reset_mul_enable: got %b want 0", mul_enable); end
        vectors++; if (mul_data_in !== 8'h00) begin miscompares++; $display("FAIL reset_mul_data_in: got %h want 00", mul_data_in); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        vectors++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: got valid=%b timeout=%b busy=%b want 0 0 0", rsp_valid, rsp_timeout, busy);
        end
        vectors++; if (rsp_data !== 64'h0 || rsp_id !== 2'd0) begin
            miscompares++; $display("FAIL reset_rsp: got data=%h id=%0d want 0 0", rsp_data, rsp_id);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        int g; bit ok;
        set_req(0, 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000);
        req_valid = 4'b0001;
        wait_grant(g, ok);
        vectors++; if (!ok || g != 0) begin miscompares++; $display("FAIL single_grant: got %0d want 0", g); end
        vectors++; if (mul_enable !== 1'b1 || mul_data_in !== 8'h3F) begin
            miscompares++; $display("FAIL single_first_byte: got en=%b data=%h want 1 3f", mul_enable, mul_data_in);
        end
        req_valid = '0;
        wait_rsp(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_rsp_timeout: got no rsp_valid want rsp_valid"); end
        vectors++; if (m_in !== 128'h3FF8_0000_0000_0000_4000_0000_0000_0000) begin
            miscompares++; $display("FAIL single_byte_stream: got %h want 3ff80000000000004000000000000000", m_in);
        end
        vectors++; if (en_cnt != 16 || en_last - en_first != 15) begin
            miscompares++; $display("FAIL single_enable_window: got cnt=%0d span=%0d want 16 15", en_cnt, en_last - en_first);
        end
        vectors++; if (rsp_data !== 64'h4008_0000_0000_0000) begin
            miscompares++; $display("FAIL single_data: got %h want 4008000000000000", rsp_data);
        end
        vectors++; if (rsp_id !== 2'd0 || rsp_timeout !== 1'b0) begin
            miscompares++; $display("FAIL single_id_timeout: got id=%0d to=%b want 0 0", rsp_id, rsp_timeout);
        end
        finish_rsp();
        vectors++; if (rsp_valid !== 1'b0 || mul_reset !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL single_release: got valid=%b mreset=%b busy=%b want 0 1 0", rsp_valid, mul_reset, busy);
        end
    endtask

    task automatic test_round_robin();
        int g; bit ok;
        int order [4] = '{0, 1, 3, 0};
        logic [63:0] ra [4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 64'h0, 64'hDEAD_BEEF_0000_0001};
        logic [63:0] rb [4] = '{64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 64'h0000_0000_CAFE_F00D};
        logic [63:0] want;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, ra[i], rb[i]);
        req_valid = 4'b1011;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, ok);
            vectors++; if (!ok || g != order[k]) begin miscompares++; $display("FAIL rr_grant_%0d: got %0d want %0d", k, g, order[k]); end
            vectors++; if (req_ready !== (N'(1) << order[k])) begin
                miscompares++; $display("FAIL rr_onehot_%0d: got %b want %b", k, req_ready, N'(1) << order[k]);
            end
            if (k == 3) req_valid = '0;
            @(negedge clk);
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rr_pulse_%0d: got %b want 0000", k, req_ready); end
            wait_rsp(ok);
            want = ra[order[k]] ^ rb[order[k]];
            vectors++; if (!ok || rsp_id !== IDW'(order[k]) || rsp_data !== want) begin
                miscompares++; $display("FAIL rr_rsp_%0d: got id=%0d data=%h want %0d %h", k, rsp_id, rsp_data, order[k], want);
            end
            finish_rsp();
            vectors++; if (mul_reset !== 1'b1) begin miscompares++; $display("FAIL rr_mul_reset_gap_%0d: got %b want 1", k, mul_reset); end
        end
    endtask

    task automatic test_backpressure();
        int g; bit ok;
        set_req(2, 64'h4010_0000_0000_0000, 64'h0000_FFFF_0000_FFFF);
        set_req(1, 64'h5555_5555_0000_0000, 64'h0000_0000_AAAA_AAAA);
        req_valid = 4'b0100;
        wait_grant(g, ok);
        vectors++; if (!ok || g != 2) begin miscompares++; $display("FAIL bp_grant: got %0d want 2", g); end
        req_valid = 4'b0010;
        wait_rsp(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid"); end
        for (int c = 0; c < 20; c++) begin
            vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 64'h4010_FFFF_0000_FFFF) begin
                miscompares++; $display("FAIL bp_hold_%0d: got valid=%b id=%0d data=%h want 1 2 4010ffff0000ffff", c, rsp_valid, rsp_id, rsp_data);
            end
            vectors++; if (req_ready !== 4'b0000 || mul_reset !== 1'b0) begin
                miscompares++; $display("FAIL bp_quiet_%0d: got ready=%b mreset=%b want 0000 0", c, req_ready, mul_reset);
            end
            @(negedge clk);
        end
        finish_rsp();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drop: got %b want 0", rsp_valid); end
        wait_grant(g, ok);
        vectors++; if (!ok || g != 1) begin miscompares++; $display("FAIL bp_next_grant: got %0d want 1", g); end
        req_valid = '0;
        wait_rsp(ok);
        vectors++; if (!ok || rsp_data !== 64'h5555_5555_AAAA_AAAA) begin
            miscompares++; $display("FAIL bp_next_data: got %h want 55555555aaaaaaaa", rsp_data);
        end
        finish_rsp();
    endtask

    task automatic test_timeout();
        int g; bit ok; bit early;
        m_stuck = 1'b1;
        set_req(0, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        req_valid = 4'b0001;
        wait_grant(g, ok);
        vectors++; if (!ok || g != 0) begin miscompares++; $display("FAIL to_grant: got %0d want 0", g); end
        req_valid = '0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mul_enable === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL to_load_end: got enable stuck high want low"); end
        early = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (rsp_valid) early = 1'b1;
        end
        @(negedge clk);
        vectors++; if (early) begin miscompares++; $display("FAIL to_early: got rsp_valid before %0d cycles want none", TIMEOUT); end
        vectors++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1) begin
            miscompares++; $display("FAIL to_flags: got valid=%b timeout=%b want 1 1", rsp_valid, rsp_timeout);
        end
        vectors++; if (rsp_data !== 64'h7FF8_0000_0000_0000) begin
            miscompares++; $display("FAIL to_data: got %h want 7ff8000000000000", rsp_data);
        end
        finish_rsp();
        m_stuck = 1'b0;
    endtask

    task automatic test_special();
        int g; bit ok;
        m_gap = 1'b1;
        set_req(3, 64'h0, 64'h7FF0_0000_0000_0000);
        req_valid = 4'b1000;
        wait_grant(g, ok);
        vectors++; if (!ok || g != 3) begin miscompares++; $display("FAIL sp_grant: got %0d want 3", g); end
        req_valid = '0;
        wait_rsp(ok);
        vectors++; if (!ok || rsp_data !== 64'h7FF0_0000_0000_0001) begin
            miscompares++; $display("FAIL sp_data: got %h want 7ff0000000000001", rsp_data);
        end
        vectors++; if (rsp_timeout !== 1'b0 || rsp_id !== 2'd3) begin
            miscompares++; $display("FAIL sp_flags: got to=%b id=%0d want 0 3", rsp_timeout, rsp_id);
        end
        vectors++; if (m_in !== 128'h0000_0000_0000_0000_7FF0_0000_0000_0000) begin
            miscompares++; $display("FAIL sp_stream: got %h want 00000000000000007ff0000000000000", m_in);
        end
        finish_rsp();
        m_gap = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int g; bit ok; bit saw;
        set_req(2, 64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718);
        req_valid = 4'b0100;
        wait_grant(g, ok);
        vectors++; if (!ok || g != 2) begin miscompares++; $display("FAIL rml_grant: got %0d want 2", g); end
        req_valid = '0;
        repeat (9) @(negedge clk);
        vectors++; if (mul_data_in !== 8'h12) begin miscompares++; $display("FAIL rml_byte9: got %h want 12", mul_data_in); end
        rst_n = 1'b0;
        #1;
        vectors++; if (mul_reset !== 1'b1 || mul_enable !== 1'b0 || mul_data_in !== 8'h00) begin
            miscompares++; $display("FAIL rml_mul_outs: got rst=%b en=%b data=%h want 1 0 00", mul_reset, mul_enable, mul_data_in);
        end
        vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_data !== 64'h0) begin
            miscompares++; $display("FAIL rml_outs: got busy=%b valid=%b ready=%b data=%h want 0 0 0000 0", busy, rsp_valid, req_ready, rsp_data);
        end
        set_req(0, 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000);
        req_valid = 4'b0101;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        rst_n = 1'b1;
        wait_grant(g, ok);
        if (rsp_valid) saw = 1'b1;
        vectors++; if (saw) begin miscompares++; $display("FAIL rml_no_rsp: got rsp_valid want none"); end
        vectors++; if (!ok || g != 0) begin miscompares++; $display("FAIL rml_regrant: got %0d want 0", g); end
        req_valid = '0;
        wait_rsp(ok);
        vectors++; if (!ok || rsp_data !== 64'h4008_0000_0000_0000 || rsp_id !== 2'd0) begin
            miscompares++; $display("FAIL rml_fresh: got data=%h id=%0d want 4008000000000000 0", rsp_data, rsp_id);
        end
        finish_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_special();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
